fpcvt_arbiter: RTL and testbench
================================

# fpcvt_arbiter

Round-robin scheduler that shares one combinational `fpcvt` converter among several requesters. Each request carries a 12-bit two's-complement sample and receives a floating-point result: sign S, 3-bit exponent E and 4-bit significand F. Results are returned tagged with the requester index. The block sits between the sample producers and the downstream consumer and provides a registered, valid/ready-handshaked wrapper around the converter.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `IDW`, default `$clog2(NREQ)`: width of the requester tag.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_data` in 12*NREQ: sample for requester i in bits [12i+11:12i].
- `req_ready` out NREQ: one-hot accept strobe.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_s` out 1, `out_e` out 3, `out_f` out 4: converted result.
- `out_id` out IDW: index of the requester that owns the result.

## Operation
- FSM states: IDLE, CONV, HOLD. Reset enters IDLE.
- IDLE:
  - When any `req_valid` bit is high, select the winner W: the first set bit at or after `ptr`, searching upward with wrap-around.
  - Drive `req_ready[W]`=1 combinationally for that cycle only.
  - At the clock edge, latch `req_data[W]` into `d_q` and W into `id_q`, then go to CONV.
- CONV:
  - `d_q` drives `fpcvt.D`.
  - At the edge, register S/E/F and `id_q` into the output registers, set `out_valid`=1, set `ptr`=(W+1) mod NREQ, and go to HOLD.
- HOLD:
  - Hold outputs stable while `out_ready`=0.
  - When `out_ready`=1 at the edge, clear `out_valid` and go to IDLE.
  - No new request is accepted in the same cycle.
- `req_ready` is all zeros in CONV and HOLD.
- A requester that drops `req_valid` before it is granted loses its turn without side effects.
- Conversion is fully delegated to `fpcvt`. No arithmetic takes place in this block beyond the pointer increment.
- Reset mid-operation:
  - Any latched request and any pending result are discarded.
  - `ptr`=0.
  - The FSM returns to IDLE.
- Reset values: `out_valid`=0, `out_s`=0, `out_e`=0, `out_f`=0, `out_id`=0, `req_ready`=0, `ptr`=0, `d_q`=0, `id_q`=0.

## Timing
- Accept edge N, then `out_valid` high after edge N+1. Latency is 2 cycles from accept to valid.
- Minimum spacing between accepts is 3 cycles (IDLE→CONV→HOLD→IDLE) when `out_ready` is held high.
- `out_*` and `out_id` change only at the CONV→HOLD edge.
- `req_ready` is a combinational function of state, `ptr` and `req_valid`. It is glitch-free relative to `clk`.
- Simultaneous requests: grant order from `ptr`=0 with all four requesters valid is 0,1,2,3,0.

## Configuration
- Macro: `FPCVT_ARB_SAT_EN`.
- Defined:
  - Adds output `out_sat` (1 bit) and register `sat_q`.
  - `sat_q` is computed in CONV from `d_q`: 1 when |D| > 1920, i.e. D > 12'h780 or D < 12'h880 signed. This includes D = 12'h800.
  - `out_sat` is registered alongside `out_f`, holds in HOLD, and resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `fpcvt_pkg`:
  - Constants `FPCVT_DW`=12, `FPCVT_EW`=3, `FPCVT_FW`=4, `FPCVT_SAT_MAG`=1920.
  - FSM state enum `arb_state_t` with values IDLE, CONV, HOLD.
- Sub-modules:
  - Instantiate the existing `fpcvt` unchanged as the datapath.
  - Add one new sub-module, `fpcvt_rr_pick`: a combinational round-robin priority selector with inputs `ptr` and `req_valid`, and outputs `grant_onehot`, `grant_idx` and `any`.

## Test plan
- Reset mid-HOLD: assert `rst_n`=0 asynchronously while `out_valid`=1 → `out_valid`=0 immediately, and the next grant after release goes to requester 0.
- Single requester 1, D=12'b000101010101 (341), `out_ready`=1 → `req_ready`=4'b0010 for one cycle, then 2 cycles later `out_s`=0, `out_e`=5, `out_f`=11, `out_id`=1.
- All four requesters valid with D = 12'h7FF, 12'h069, 12'h07D, 12'hF00 → results in id order 0,1,2,3:
  - 12'h7FF: S=0, E=7, F=15, sat=1 (with `FPCVT_ARB_SAT_EN`).
  - 12'h069: S=0, E=3, F=13.
  - 12'h07D: S=0, E=4, F=8 (rounding carry).
  - 12'hF00: S=1, E=5, F=8.
- Backpressure: `out_ready`=0 for 10 cycles in HOLD → outputs stable, `req_ready`=0 throughout, then one result consumed and the next grant is made.
- Fairness: requesters 0 and 2 continuously valid for 8 grants → grants alternate 0,2,0,2,…, and requester 2 is never starved.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// Shared constants, FSM state type and saturation helper for the fpcvt arbiter slice.
package fpcvt_pkg;

  localparam int unsigned FPCVT_DW      = 12;
  localparam int unsigned FPCVT_EW      = 3;
  localparam int unsigned FPCVT_FW      = 4;
  localparam int unsigned FPCVT_SAT_MAG = 1920;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  // |d| > FPCVT_SAT_MAG on a two's-complement sample; 12'h800 counts as saturated.
  function automatic logic fpcvt_is_sat(input logic [FPCVT_DW-1:0] d);
    return ($signed(d) > $signed(FPCVT_DW'(FPCVT_SAT_MAG))) ||
           ($signed(d) < -$signed(FPCVT_DW'(FPCVT_SAT_MAG)));
  endfunction

endpackage

// File: rtl/fpcvt.sv
// Combinational 12-bit two's-complement to sign/3-bit exponent/4-bit significand converter.
module fpcvt
  import fpcvt_pkg::*;
(
  input  logic [FPCVT_DW-1:0] D,
  output logic                S,
  output logic [FPCVT_EW-1:0] E,
  output logic [FPCVT_FW-1:0] F
);

  logic [FPCVT_DW-1:0] mag;
  logic [3:0]          msb;
  logic [3:0]          shift;
  logic [4:0]          f5;
  logic [4:0]          rnd;
  logic [3:0]          e_full;

  always_comb begin
    S      = D[FPCVT_DW-1];
    E      = '0;
    F      = '0;
    mag    = D[FPCVT_DW-1] ? FPCVT_DW'(-D) : D;
    msb    = 4'd0;
    shift  = 4'd0;
    f5     = 5'd0;
    rnd    = 5'd0;
    e_full = 4'd0;
    for (int unsigned i = 0; i < FPCVT_DW; i++) begin
      if (mag[i]) msb = 4'(i);
    end
    if (msb <= 4'd3) begin
      F = mag[3:0];
    end else begin
      // Keep 4 significant bits plus one round bit, round half up, then clamp.
      shift  = msb - 4'd3;
      f5     = 5'(mag >> (shift - 4'd1));
      rnd    = {1'b0, f5[4:1]} + {4'd0, f5[0]};
      e_full = shift + {3'd0, rnd[4]};
      if (e_full > 4'd7) begin
        E = 3'd7;
        F = 4'hF;
      end else begin
        E = e_full[2:0];
        F = rnd[4] ? 4'h8 : rnd[3:0];
      end
    end
  end

endmodule

// File: rtl/fpcvt_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr, with wrap.
module fpcvt_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [IDW-1:0]  ptr,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned j;
      j = (int'(ptr) + i) % NREQ;
      if (!any && req_valid[j]) begin
        any             = 1'b1;
        grant_onehot[j] = 1'b1;
        grant_idx       = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/fpcvt_arbiter.sv
// Round-robin arbiter sharing one fpcvt among NREQ requesters with a registered result.
// Optional FPCVT_ARB_SAT_EN adds the out_sat magnitude-saturation flag.
module fpcvt_arbiter
  import fpcvt_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [FPCVT_DW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_s,
  output logic [FPCVT_EW-1:0]      out_e,
  output logic [FPCVT_FW-1:0]      out_f,
  output logic [IDW-1:0]           out_id
`ifdef FPCVT_ARB_SAT_EN
  , output logic                   out_sat
`endif
);

  arb_state_t          state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [FPCVT_DW-1:0] d_q, d_d;
  logic [IDW-1:0]      id_q, id_d;
  logic                out_valid_q, out_valid_d;
  logic                out_s_q, out_s_d;
  logic [FPCVT_EW-1:0] out_e_q, out_e_d;
  logic [FPCVT_FW-1:0] out_f_q, out_f_d;
  logic [IDW-1:0]      out_id_q, out_id_d;
`ifdef FPCVT_ARB_SAT_EN
  logic                sat_q, sat_d;
`endif

  logic [NREQ-1:0]     pick_onehot;
  logic [IDW-1:0]      pick_idx;
  logic                pick_any;
  logic                cv_s;
  logic [FPCVT_EW-1:0] cv_e;
  logic [FPCVT_FW-1:0] cv_f;

  fpcvt_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .ptr          (ptr_q),
    .req_valid    (req_valid),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .any          (pick_any)
  );

  fpcvt u_cvt (
    .D (d_q),
    .S (cv_s),
    .E (cv_e),
    .F (cv_f)
  );

  // Next-state, grant strobe and result capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    d_d         = d_q;
    id_d        = id_q;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_e_d     = out_e_q;
    out_f_d     = out_f_q;
    out_id_d    = out_id_q;
`ifdef FPCVT_ARB_SAT_EN
    sat_d       = sat_q;
`endif
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_onehot;
          d_d       = req_data[FPCVT_DW*int'(pick_idx) +: FPCVT_DW];
          id_d      = pick_idx;
          state_d   = CONV;
        end
      end
      CONV: begin
        out_s_d     = cv_s;
        out_e_d     = cv_e;
        out_f_d     = cv_f;
        out_id_d    = id_q;
        out_valid_d = 1'b1;
`ifdef FPCVT_ARB_SAT_EN
        sat_d       = fpcvt_is_sat(d_q);
`endif
        ptr_d       = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      d_q         <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_s_q     <= 1'b0;
      out_e_q     <= '0;
      out_f_q     <= '0;
      out_id_q    <= '0;
`ifdef FPCVT_ARB_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      d_q         <= d_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_e_q     <= out_e_d;
      out_f_q     <= out_f_d;
      out_id_q    <= out_id_d;
`ifdef FPCVT_ARB_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_e     = out_e_q;
  assign out_f     = out_f_q;
  assign out_id    = out_id_q;
`ifdef FPCVT_ARB_SAT_EN
  assign out_sat   = sat_q;
`endif

endmodule

// File: tb/tb_fpcvt_arbiter.sv
// Directed self-checking bench for fpcvt_arbiter (NREQ=4); checks out_sat when FPCVT_ARB_SAT_EN is set.
module tb_fpcvt_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [12*NREQ-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            out_valid;
  logic            out_ready;
  logic            out_s;
  logic [2:0]      out_e;
  logic [3:0]      out_f;
  logic [IDW-1:0]  out_id;
`ifdef FPCVT_ARB_SAT_EN
  logic            out_sat;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fpcvt_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_id    (out_id)
`ifdef FPCVT_ARB_SAT_EN
    , .out_sat (out_sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic chk_result(input string tag, input int id, input int s, input int e, input int f);
    check({tag, "_id"}, 32'(out_id), 32'(id));
    check({tag, "_s"},  32'(out_s),  32'(s));
    check({tag, "_e"},  32'(out_e),  32'(e));
    check({tag, "_f"},  32'(out_f),  32'(f));
    check({tag, "_rdy0"}, 32'(req_ready), 32'd0);
  endtask

  // Expected results for the all-four sweep: 7FF, 069, 07D, F00, then 7FF again.
  int exp_id [5] = '{0, 1, 2, 3, 0};
  int exp_s  [5] = '{0, 0, 0, 1, 0};
  int exp_e  [5] = '{7, 3, 4, 5, 7};
  int exp_f  [5] = '{15, 13, 8, 8, 15};
  int exp_sat[5] = '{1, 0, 0, 0, 1};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_id",    32'(out_id),    32'd0);
    check("rst_sef",   32'({out_s, out_e, out_f}), 32'd0);
`ifdef FPCVT_ARB_SAT_EN
    check("rst_sat",   32'(out_sat),   32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester 1, D=341
    req_data[12*1 +: 12] = 12'h155;
    req_valid = 4'b0010;
    out_ready = 1'b1;
    #1 check("single_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    check("single_conv_rdy", 32'(req_ready), 32'd0);
    check("single_conv_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("single_vld", 32'(out_valid), 32'd1);
    chk_result("single", 1, 0, 5, 11);
    @(negedge clk);
    check("single_drain", 32'(out_valid), 32'd0);

    // Reset in HOLD: ptr is 2, grant requester 2 then reset while out_valid=1
    req_data[12*2 +: 12] = 12'h800;
    req_valid = 4'b0100;
    out_ready = 1'b0;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("hold_vld", 32'(out_valid), 32'd1);
    check("hold_id",  32'(out_id),    32'd2);
    #2 rst_n = 1'b0;
    #1 check("async_rst_vld", 32'(out_valid), 32'd0);
    check("async_rst_id", 32'(out_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four valid: order from ptr=0 must be 0,1,2,3,0
    req_data[12*0 +: 12] = 12'h7FF;
    req_data[12*1 +: 12] = 12'h069;
    req_data[12*2 +: 12] = 12'h07D;
    req_data[12*3 +: 12] = 12'hF00;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid("all4_wait");
      chk_result("all4", exp_id[i], exp_s[i], exp_e[i], exp_f[i]);
`ifdef FPCVT_ARB_SAT_EN
      check("all4_sat", 32'(out_sat), 32'(exp_sat[i]));
`endif
    end
    @(negedge clk);

    // Backpressure: hold result of requester 1 for 10 cycles
    out_ready = 1'b0;
    wait_valid("bp_wait");
    chk_result("bp", 1, 0, 3, 13);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_vld",   32'(out_valid), 32'd1);
      check("bp_id",    32'(out_id),    32'd1);
      check("bp_f",     32'(out_f),     32'd13);
      check("bp_e",     32'(out_e),     32'd3);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain",  32'(out_valid), 32'd0);
    check("bp_next",   32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    check("bp_conv_rdy", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk_result("bp_next", 2, 0, 4, 8);
    @(negedge clk);

    // Fairness: requesters 0 and 2 continuously valid from ptr=0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      wait_valid("fair_wait");
      check("fair_id", 32'(out_id), (i % 2 == 0) ? 32'd0 : 32'd2);
      check("fair_e",  32'(out_e),  (i % 2 == 0) ? 32'd7 : 32'd4);
    end
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
